// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : N-channel programmable integer clock divider with glitch-free
//                ratio updates at period boundaries and 50% duty on odd ratios.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       err
);

    localparam logic [CNT_W-1:0] c_div_init  = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] c_min_ratio = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_act;
        logic [CNT_W-1:0] w_act_nxt;
        logic [CNT_W-1:0] r_pend;
        logic [CNT_W-1:0] w_pend_nxt;
        logic             r_pend_vld;
        logic             w_pend_vld_nxt;
        logic             r_clk_p;
        logic             w_clk_p_nxt;
        logic             r_clk_n;
        logic             r_tick;
        logic             w_tick_nxt;
        logic             r_err;

        logic [CNT_W-1:0] w_ratio;
        logic             w_load_ok;
        logic             w_load_bad;
        logic [CNT_W-1:0] w_pend_eff;
        logic             w_pend_eff_vld;
        logic [CNT_W-1:0] w_cnt_inc;
        logic [CNT_W-1:0] w_half;
        logic             w_start;
        logic             w_boundary;

        assign w_ratio    = div_ratio[gi*CNT_W +: CNT_W];
        assign w_load_ok  = load[gi] && (w_ratio >= c_min_ratio);
        assign w_load_bad = load[gi] && (w_ratio <  c_min_ratio);

        // A load landing in the same cycle as a boundary/start must be seen by it.
        assign w_pend_eff     = w_load_ok ? w_ratio : r_pend;
        assign w_pend_eff_vld = w_load_ok | r_pend_vld;

        assign w_cnt_inc  = r_cnt + c_one;
        assign w_half     = r_act >> 1;
        assign w_start    = ch_en[gi] && (sync || (r_state == ST_IDLE));
        assign w_boundary = (r_state == ST_RUN) && (r_cnt == (r_act - c_one));

        always_comb begin
            w_state_nxt    = r_state;
            w_cnt_nxt      = r_cnt;
            w_act_nxt      = r_act;
            w_pend_nxt     = w_pend_eff;
            w_pend_vld_nxt = w_pend_eff_vld;
            w_clk_p_nxt    = 1'b0;
            w_tick_nxt     = 1'b0;
            if (w_start || w_boundary) begin
                if (w_pend_eff_vld) begin
                    w_act_nxt      = w_pend_eff;
                    w_pend_vld_nxt = 1'b0;
                end
                w_cnt_nxt = '0;
                if (ch_en[gi]) begin
                    w_state_nxt = ST_RUN;
                    w_clk_p_nxt = 1'b1;
                    w_tick_nxt  = 1'b1;
                end else begin
                    // Park low at the boundary so the last pulse is never cut short.
                    w_state_nxt = ST_IDLE;
                end
            end else if (r_state == ST_RUN) begin
                w_cnt_nxt   = w_cnt_inc;
                w_clk_p_nxt = (w_cnt_inc < w_half);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_act      <= c_div_init;
                r_pend     <= '0;
                r_pend_vld <= 1'b0;
                r_clk_p    <= 1'b0;
                r_tick     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_cnt      <= w_cnt_nxt;
                r_act      <= w_act_nxt;
                r_pend     <= w_pend_nxt;
                r_pend_vld <= w_pend_vld_nxt;
                r_clk_p    <= w_clk_p_nxt;
                r_tick     <= w_tick_nxt;
                if (w_load_bad) begin
                    r_err <= 1'b1;
                end else if (w_load_ok) begin
                    r_err <= 1'b0;
                end
            end
        end

        // Half-cycle delayed copy stretches the high phase by 0.5 clk for odd ratios.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_clk_n <= 1'b0;
            end else begin
                r_clk_n <= r_clk_p;
            end
        end

        assign clk_out[gi] = r_clk_p | (r_act[0] & r_clk_n);
        assign tick[gi]    = r_tick;
        assign err[gi]     = r_err;
    end

endmodule
`default_nettype wire
